// File: rtl/kc_ls1u_pkg.sv
// Shared types and default sizes for the KC_LS1u instruction fetch slice.
package kc_ls1u_pkg;

    localparam int KC_ADDR_WIDTH  = 24;
    localparam int KC_INSTR_WIDTH = 16;
    localparam logic [KC_ADDR_WIDTH-1:0] KC_RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ifetch_state_t;

endpackage

// File: rtl/kc_ls1u_ifetch_if.sv
// Instruction-memory and decode-side signals of the fetch unit.
interface kc_ls1u_ifetch_if
    import kc_ls1u_pkg::*;
#(
    parameter int ADDR_WIDTH  = KC_ADDR_WIDTH,
    parameter int INSTR_WIDTH = KC_INSTR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_req;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_instr;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   jmp_valid;
    logic [ADDR_WIDTH-1:0]  jmp_addr;

    modport master (
        output mem_addr, mem_req, instr, instr_pc, instr_valid,
        input  mem_ack, mem_instr, instr_ready, jmp_valid, jmp_addr
    );

    modport slave (
        input  mem_addr, mem_req, instr, instr_pc, instr_valid,
        output mem_ack, mem_instr, instr_ready, jmp_valid, jmp_addr
    );

endinterface

// File: rtl/kc_ls1u_ifetch_fifo.sv
// Prefetch FIFO of {addr, instr}; flush wins over push and pop.
module kc_ls1u_ifetch_fifo
    import kc_ls1u_pkg::*;
#(
    parameter int ADDR_WIDTH  = KC_ADDR_WIDTH,
    parameter int INSTR_WIDTH = KC_INSTR_WIDTH,
    parameter int DEPTH       = 2,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  push_addr,
    input  logic [INSTR_WIDTH-1:0] push_instr,
    output logic [ADDR_WIDTH-1:0]  head_addr,
    output logic [INSTR_WIDTH-1:0] head_instr,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    logic [ADDR_WIDTH-1:0]  addr_mem  [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                addr_mem[wr_ptr]  <= push_addr;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kc_ls1u_ifetch.sv
// KC_LS1u instruction fetch: one-outstanding-request fetcher feeding a prefetch FIFO,
// with jump redirect and discard of an in-flight word (DRAIN).
module kc_ls1u_ifetch
    import kc_ls1u_pkg::*;
#(
    parameter int ADDR_WIDTH  = KC_ADDR_WIDTH,
    parameter int INSTR_WIDTH = KC_INSTR_WIDTH,
    parameter int FIFO_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(KC_RESET_PC),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    kc_ls1u_ifetch_if.master bus
);

    ifetch_state_t          state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   mem_req;
    logic                   handshake;
    logic                   jump;
    logic                   push;
    logic                   pop;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;

    // mem_req depends only on registered state, never on instr_ready.
    assign mem_req   = ((state == FETCH) && !full) || (state == DRAIN);
    assign handshake = mem_req && bus.mem_ack;
    assign jump      = bus.jmp_valid && (state != IDLE);
    assign push      = (state == FETCH) && handshake && !bus.jmp_valid;
    assign pop       = !empty && bus.instr_ready && !bus.jmp_valid;

    assign bus.mem_addr    = pc;
    assign bus.mem_req     = mem_req;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_addr;
    assign bus.instr_valid = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (bus.jmp_valid) begin
                        // An unacknowledged request must finish before pc may move.
                        if (mem_req && !bus.mem_ack) state <= DRAIN;
                        else                         pc    <= bus.jmp_addr;
                    end else if (handshake) begin
                        pc <= pc + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (bus.mem_ack) begin
                        state <= FETCH;
                        pc    <= bus.jmp_valid ? bus.jmp_addr : target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (jump) target <= bus.jmp_addr;
    end

    kc_ls1u_ifetch_fifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (jump),
        .push_addr  (pc),
        .push_instr (bus.mem_instr),
        .head_addr  (head_addr),
        .head_instr (head_instr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_kc_ls1u_ifetch.sv
// Directed bench for kc_ls1u_ifetch with a scoreboard of expected {pc, instr} deliveries.
module tb_kc_ls1u_ifetch;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   vectors = 0;
    int   fails   = 0;
    int   n2      = 0;
    logic [39:0] q  [$];
    logic [39:0] q2 [$];

    always #5 clk = ~clk;

    kc_ls1u_ifetch_if #(.ADDR_WIDTH(24), .INSTR_WIDTH(16)) bus ();
    kc_ls1u_ifetch_if #(.ADDR_WIDTH(24), .INSTR_WIDTH(16)) bus2 ();

    kc_ls1u_ifetch #(.FIFO_DEPTH(2), .RESET_PC(24'h000000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    kc_ls1u_ifetch #(.FIFO_DEPTH(2), .RESET_PC(24'hFFFFFE)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2)
    );

    function automatic logic [15:0] rom(input logic [23:0] a);
        case (a)
            24'd0:   return 16'h3101;
            24'd1:   return 16'h3200;
            24'd2:   return 16'h3400;
            24'd10:  return 16'h0DFF;
            24'd16:  return 16'h1794;
            24'd20:  return 16'h17C0;
            default: return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    assign bus.mem_instr  = rom(bus.mem_addr);
    assign bus2.mem_instr = rom(bus2.mem_addr);

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input bit second, input logic [23:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [23:0] a;
            a = start + 24'(i);
            if (second) q2.push_back({a, rom(a)});
            else        q.push_back({a, rom(a)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready && !bus.jmp_valid) begin
            if (q.size() == 0) check("deliver_unexpected", 40'(q.size()), 40'd1);
            else               check("deliver", {bus.instr_pc, bus.instr}, q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst2_n && bus2.instr_valid && bus2.instr_ready && !bus2.jmp_valid) begin
            n2++;
            if (q2.size() == 0) check("deliver2_unexpected", 40'(q2.size()), 40'd1);
            else                check("deliver2", {bus2.instr_pc, bus2.instr}, q2.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        bus.mem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        bus.jmp_valid = 1'b0;
        bus.jmp_addr = '0;
        bus2.mem_ack = 1'b1;
        bus2.instr_ready = 1'b1;
        bus2.jmp_valid = 1'b0;
        bus2.jmp_addr = '0;
        repeat (2) tick();

        // Reset state
        @(negedge clk);
        check("rst_mem_req", 40'(bus.mem_req), 40'd0);
        check("rst_valid", 40'(bus.instr_valid), 40'd0);
        check("rst_mem_addr", 40'(bus.mem_addr), 40'd0);
        check("rst_instr", 40'(bus.instr), 40'd0);
        check("rst_instr_pc", 40'(bus.instr_pc), 40'd0);
        check("rst2_mem_addr", 40'(bus2.mem_addr), 40'hFFFFFE);
        q.delete();
        push_run(1'b0, 24'd0, 40);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_mem_req", 40'(bus.mem_req), 40'd0);
        @(negedge clk);
        check("fetch_mem_req", 40'(bus.mem_req), 40'd1);
        check("fetch_mem_addr", 40'(bus.mem_addr), 40'd0);
        repeat (3) begin
            @(negedge clk);
            check("b2b_valid", 40'(bus.instr_valid), 40'd1);
        end

        // Fill the FIFO with pc 3,4 then jump to 10
        tick();
        bus.instr_ready = 1'b0;
        tick();
        check("full_mem_req", 40'(bus.mem_req), 40'd0);
        check("full_head_pc", 40'(bus.instr_pc), 40'd3);
        bus.jmp_valid = 1'b1;
        bus.jmp_addr = 24'd10;
        bus.instr_ready = 1'b1;
        q.delete();
        push_run(1'b0, 24'd10, 40);
        tick();
        bus.jmp_valid = 1'b0;
        check("jmp_mem_addr", 40'(bus.mem_addr), 40'd10);
        check("jmp_flushed", 40'(bus.instr_valid), 40'd0);
        tick();
        check("jmp_valid_t2", 40'(bus.instr_valid), 40'd1);
        check("jmp_head", {bus.instr_pc, bus.instr}, {24'd10, 16'h0DFF});
        repeat (4) tick();
        bus.instr_ready = 1'b0;

        // Decode stall right after reset
        rst_n = 1'b0;
        tick();
        q.delete();
        push_run(1'b0, 24'd0, 40);
        rst_n = 1'b1;
        repeat (6) tick();
        check("stall_mem_req", 40'(bus.mem_req), 40'd0);
        check("stall_mem_addr", 40'(bus.mem_addr), 40'd2);
        check("stall_valid", 40'(bus.instr_valid), 40'd1);
        check("stall_head_pc", 40'(bus.instr_pc), 40'd0);
        bus.instr_ready = 1'b1;
        repeat (12) tick();
        bus.instr_ready = 1'b0;
        repeat (3) tick();
        check("burst_full_valid", 40'(bus.instr_valid), 40'd1);
        check("burst_full_req", 40'(bus.mem_req), 40'd0);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 40'(bus.instr_valid), 40'd0);
        check("async_mem_req", 40'(bus.mem_req), 40'd0);
        check("async_mem_addr", 40'(bus.mem_addr), 40'd0);
        tick();
        q.delete();
        push_run(1'b0, 24'd0, 40);
        bus.instr_ready = 1'b1;
        rst_n = 1'b1;
        repeat (6) tick();

        // Slow memory: jump while a request waits for ack
        rst_n = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        q.delete();
        rst_n = 1'b1;
        tick();
        tick();
        bus.jmp_valid = 1'b1;
        bus.jmp_addr = 24'd16;
        q.delete();
        push_run(1'b0, 24'd16, 40);
        tick();
        bus.jmp_valid = 1'b0;
        check("drain_mem_req", 40'(bus.mem_req), 40'd1);
        check("drain_addr_hold", 40'(bus.mem_addr), 40'd0);
        tick();
        bus.mem_ack = 1'b1;
        check("drain_addr_ack", 40'(bus.mem_addr), 40'd0);
        tick();
        check("drain_exit_addr", 40'(bus.mem_addr), 40'd16);
        tick();
        check("drain_head_valid", 40'(bus.instr_valid), 40'd1);
        check("drain_head", {bus.instr_pc, bus.instr}, {24'd16, 16'h1794});
        bus.mem_ack = 1'b0;
        tick();
        bus.jmp_valid = 1'b1;
        bus.jmp_addr = 24'd50;
        q.delete();
        tick();
        bus.jmp_addr = 24'd20;
        q.delete();
        push_run(1'b0, 24'd20, 40);
        check("drain2_mem_req", 40'(bus.mem_req), 40'd1);
        check("drain2_addr_hold", 40'(bus.mem_addr), 40'd17);
        tick();
        bus.jmp_valid = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        check("drain2_exit_addr", 40'(bus.mem_addr), 40'd20);
        tick();
        check("drain2_head", {bus.instr_pc, bus.instr}, {24'd20, 16'h17C0});
        repeat (3) tick();
        bus.instr_ready = 1'b0;

        // pc wrap from a high reset address
        q2.delete();
        push_run(1'b1, 24'hFFFFFE, 40);
        tick();
        rst2_n = 1'b1;
        repeat (8) tick();
        bus2.instr_ready = 1'b0;
        check("wrap_count", 40'(n2), 40'd6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
